// File: rtl/pipe_mux_if.sv
// Handshake bundle for pipe_mux_nto1: selector/data offer on the input side,
// registered selected word with error flag on the output side.
interface pipe_mux_if #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = 2
);
    logic [SelBits-1:0]       Selector;
    logic [NInputs*NBits-1:0] MUX_Data;
    logic                     In_Valid;
    logic                     In_Ready;
    logic                     Flush;
    logic [NBits-1:0]         Out_Data;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic                     Out_SelError;

    modport master (
        output Selector, MUX_Data, In_Valid, Flush, Out_Ready,
        input  In_Ready, Out_Data, Out_Valid, Out_SelError
    );

    modport slave (
        input  Selector, MUX_Data, In_Valid, Flush, Out_Ready,
        output In_Ready, Out_Data, Out_Valid, Out_SelError
    );
endinterface

// File: rtl/pipe_mux_nto1.sv
// Registered N-to-1 multiplexer with valid/ready handshake and a two-entry
// skid buffer (main drives the outputs, skid absorbs one stalled word).
module pipe_mux_nto1 #(
    parameter int NBits   = 32,
    parameter int NInputs = 4,
    parameter int SelBits = 2
) (
    input logic       clk,
    input logic       reset,
    pipe_mux_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [NBits-1:0] in_data_p0;
    logic             in_err_p0;
    logic [NBits-1:0] main_data_p1, skid_data_p1;
    logic             main_err_p1, skid_err_p1;
    logic             main_vld_p1, skid_vld_p1;
    logic             accept;
    logic             load_main_in, load_main_skid, load_skid_in;

    // Out-of-range selectors fall back to input 0 and flag the entry.
    function automatic logic [NBits:0] select_word(
        input logic [SelBits-1:0]       sel,
        input logic [NInputs*NBits-1:0] data
    );
        logic [NBits:0] word;
        word = {data[NBits-1:0], 1'b1};
        for (int k = 0; k < NInputs; k++) begin
            if (int'(sel) == k) word = {data[k*NBits +: NBits], 1'b0};
        end
        return word;
    endfunction

    // Stage p0: combinational selection of the offered word
    assign {in_data_p0, in_err_p0} = select_word(bus.Selector, bus.MUX_Data);

    assign main_vld_p1 = (state_q != EMPTY);
    assign skid_vld_p1 = (state_q == TWO);
    assign accept      = bus.In_Valid && !skid_vld_p1;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d      = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && bus.Out_Ready) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d      = TWO;
                    load_skid_in = 1'b1;
                end else if (bus.Out_Ready) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (bus.Out_Ready) begin
                    state_d        = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards held entries and anything offered this cycle.
        if (bus.Flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Stage p1: main entry is cleared by reset so the idle output reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_data_p1 <= '0;
            main_err_p1  <= 1'b0;
        end else if (load_main_in) begin
            main_data_p1 <= in_data_p0;
            main_err_p1  <= in_err_p0;
        end else if (load_main_skid) begin
            main_data_p1 <= skid_data_p1;
            main_err_p1  <= skid_err_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid_in) begin
            skid_data_p1 <= in_data_p0;
            skid_err_p1  <= in_err_p0;
        end
    end

    assign bus.In_Ready     = !skid_vld_p1;
    assign bus.Out_Data     = main_data_p1;
    assign bus.Out_Valid    = main_vld_p1;
    assign bus.Out_SelError = main_err_p1;

endmodule

// File: tb/tb_pipe_mux_nto1.sv
// Directed and random-backpressure bench for pipe_mux_nto1 (5-input and
// 3-input instances) with immediate-assertion checks.
module tb_pipe_mux_nto1;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    pipe_mux_if #(.NBits(32), .NInputs(5), .SelBits(3)) bus ();
    pipe_mux_if #(.NBits(32), .NInputs(3), .SelBits(2)) bus_b ();

    pipe_mux_nto1 #(.NBits(32), .NInputs(5), .SelBits(3)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    pipe_mux_nto1 #(.NBits(32), .NInputs(3), .SelBits(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] base, input logic [2:0] sel);
        bus.Selector = sel;
        for (int k = 0; k < 5; k++) bus.MUX_Data[k*32 +: 32] = base + 32'(k);
    endtask

    logic [32:0]  sb[$];
    logic [32:0]  exp_w;
    logic [31:0]  w[5];
    logic [2:0]   rsel;
    int           accepted;
    int           cycles;

    initial begin
        reset = 1'b0;
        bus.Selector = '0; bus.MUX_Data = '0; bus.In_Valid = 1'b0;
        bus.Flush = 1'b0;  bus.Out_Ready = 1'b0;
        bus_b.Selector = '0; bus_b.MUX_Data = '0; bus_b.In_Valid = 1'b0;
        bus_b.Flush = 1'b0;  bus_b.Out_Ready = 1'b0;

        // Reset state
        step();
        check("rst_out_valid", bus.Out_Valid, 0);
        check("rst_out_data", bus.Out_Data, 0);
        check("rst_sel_error", bus.Out_SelError, 0);
        check("rst_in_ready", bus.In_Ready, 1);
        reset = 1'b1;
        step();

        // Streaming at full rate, selector 2
        bus.In_Valid = 1'b1; bus.Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(32'h10 + 32'h100 * i, 3'd2);
            check("stream_in_ready", bus.In_Ready, 1);
            step();
            check("stream_valid", bus.Out_Valid, 1);
            check("stream_data", bus.Out_Data, 32'h12 + 32'h100 * i);
        end
        bus.In_Valid = 1'b0;
        step();
        check("stream_drained", bus.Out_Valid, 0);

        // Stall absorption: A, B accepted, C refused until space frees up
        bus.Out_Ready = 1'b0; bus.In_Valid = 1'b1;
        offer(32'h1000, 3'd1);
        check("stall_a_ready", bus.In_Ready, 1);
        step();
        offer(32'h2000, 3'd3);
        check("stall_b_ready", bus.In_Ready, 1);
        step();
        offer(32'h3000, 3'd4);
        check("stall_c_refused", bus.In_Ready, 0);
        check("stall_hold_a", bus.Out_Data, 32'h1001);
        step();
        check("stall_still_full", bus.In_Ready, 0);
        check("stall_still_a", bus.Out_Data, 32'h1001);
        bus.Out_Ready = 1'b1;
        step();
        check("drain_b_data", bus.Out_Data, 32'h2003);
        check("drain_ready_back", bus.In_Ready, 1);
        step();
        check("drain_c_data", bus.Out_Data, 32'h3004);
        check("drain_c_valid", bus.Out_Valid, 1);
        bus.In_Valid = 1'b0;
        step();
        check("drain_empty", bus.Out_Valid, 0);

        // Out-of-range selector on the 3-input instance
        bus_b.MUX_Data = {32'hCAFE, 32'hBEEF, 32'hDEAD};
        bus_b.Selector = 2'd3; bus_b.In_Valid = 1'b1; bus_b.Out_Ready = 1'b1;
        step();
        check("oor_data", bus_b.Out_Data, 32'hDEAD);
        check("oor_err", bus_b.Out_SelError, 1);
        bus_b.Selector = 2'd1;
        step();
        check("inrange_data", bus_b.Out_Data, 32'hBEEF);
        check("inrange_err", bus_b.Out_SelError, 0);
        bus_b.In_Valid = 1'b0;
        step();
        check("oor_drained", bus_b.Out_Valid, 0);

        // Flush in TWO with an offer pending
        bus.Out_Ready = 1'b0; bus.In_Valid = 1'b1;
        offer(32'h6000, 3'd0);
        step();
        offer(32'h7000, 3'd1);
        step();
        check("flush_two_full", bus.In_Ready, 0);
        offer(32'h8000, 3'd2);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0; bus.In_Valid = 1'b0;
        check("flush_two_valid", bus.Out_Valid, 0);
        check("flush_two_ready", bus.In_Ready, 1);
        bus.Out_Ready = 1'b1;
        step();
        check("flush_two_no_ghost", bus.Out_Valid, 0);

        // Flush in ONE while a word is accepted: that word is discarded
        bus.Out_Ready = 1'b0; bus.In_Valid = 1'b1;
        offer(32'h9000, 3'd0);
        step();
        check("flush_one_valid", bus.Out_Valid, 1);
        offer(32'hA000, 3'd1);
        bus.Flush = 1'b1;
        step();
        bus.Flush = 1'b0; bus.In_Valid = 1'b0; bus.Out_Ready = 1'b1;
        check("flush_one_cleared", bus.Out_Valid, 0);
        check("flush_one_ready", bus.In_Ready, 1);
        step();
        check("flush_one_no_ghost", bus.Out_Valid, 0);

        // Asynchronous reset while holding two flagged words
        bus.Out_Ready = 1'b0; bus.In_Valid = 1'b1;
        offer(32'hB000, 3'd6);
        step();
        step();
        bus.In_Valid = 1'b0;
        check("pre_rst_full", bus.In_Ready, 0);
        check("pre_rst_err", bus.Out_SelError, 1);
        check("pre_rst_data", bus.Out_Data, 32'hB000);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", bus.Out_Valid, 0);
        check("arst_data", bus.Out_Data, 0);
        check("arst_err", bus.Out_SelError, 0);
        check("arst_ready", bus.In_Ready, 1);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Random backpressure against a FIFO scoreboard
        accepted = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 20000) begin
            bus.In_Valid  = ($urandom_range(0, 3) != 0);
            bus.Out_Ready = ($urandom_range(0, 2) != 0);
            rsel = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) w[k] = $urandom;
            bus.Selector = rsel;
            for (int k = 0; k < 5; k++) bus.MUX_Data[k*32 +: 32] = w[k];
            check("rnd_out_valid", bus.Out_Valid, (sb.size() != 0));
            check("rnd_in_ready", bus.In_Ready, (sb.size() < 2));
            if (bus.Out_Valid && bus.Out_Ready && sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("rnd_data", bus.Out_Data, exp_w[31:0]);
                check("rnd_err", bus.Out_SelError, exp_w[32]);
            end
            if (bus.In_Valid && bus.In_Ready) begin
                if (rsel < 3'd5) sb.push_back({1'b0, w[rsel]});
                else             sb.push_back({1'b1, w[0]});
                accepted++;
            end
            step();
            cycles++;
        end
        check("rnd_word_count", accepted, 1000);

        bus.In_Valid = 1'b0; bus.Out_Ready = 1'b1;
        cycles = 0;
        while (sb.size() != 0 && cycles < 10) begin
            check("drain_out_valid", bus.Out_Valid, 1);
            exp_w = sb.pop_front();
            check("drain_data", bus.Out_Data, exp_w[31:0]);
            check("drain_err", bus.Out_SelError, exp_w[32]);
            step();
            cycles++;
        end
        check("rnd_scoreboard_empty", sb.size(), 0);
        check("rnd_final_idle", bus.Out_Valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_mux_nto1.md
# pipe_mux_nto1

Registered N-to-1 datapath multiplexer with a valid/ready handshake and a two-entry skid buffer. It is the parametrised successor to the fixed 3-input combinational selector. It is used wherever the pipeline selects an operand or result (forwarding paths, write-back source) and must absorb a one-cycle downstream stall without dropping data. The selected word is captured one cycle after acceptance, together with an out-of-range-selector flag, and can be flushed on a branch or hazard.

## Interface
Parameters:
- NBits, 32, data word width.
- NInputs, 4, number of data inputs; legal range 2..16.
- SelBits, 2, selector width; the integrator sets it to at least ceil(log2(NInputs)).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- Selector  input  SelBits  index of the input to forward.
- MUX_Data  input  NInputs*NBits  flattened inputs; input k occupies bits [k*NBits +: NBits].
- In_Valid  input  1  producer offers Selector/MUX_Data this cycle.
- In_Ready  output  1  block can accept this cycle.
- Flush  input  1  synchronous discard of all held entries.
- Out_Data  output  NBits  selected word at the head of the buffer.
- Out_Valid  output  1  Out_Data is valid.
- Out_Ready  input  1  consumer takes Out_Data this cycle.
- Out_SelError  output  1  head entry was captured with Selector >= NInputs.

## Operation
- Accept when In_Valid && In_Ready. Transfer out when Out_Valid && Out_Ready.
- Selection: a Selector value below NInputs picks input Selector. Any other value picks input 0 and sets the entry's error bit.
- Each entry holds {data[NBits], err}. There are two entries: main (drives the outputs) and skid.
- In_Ready = !skid_valid. It is a decode of a registered bit only and has no combinational path from Out_Ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY:
    - accept → ONE (main ← input).
  - ONE:
    - accept && Out_Ready → ONE (main ← input).
    - accept && !Out_Ready → TWO (skid ← input).
    - !accept && Out_Ready → EMPTY.
    - otherwise → ONE (hold).
  - TWO (In_Ready = 0):
    - Out_Ready → ONE (main ← skid, skid cleared).
    - otherwise → TWO (hold).
- Held entries never change while stalled. Out_Data, Out_Valid and Out_SelError are stable until transfer.
- Flush has priority over everything in the same cycle:
  - both valid bits clear and the next state is EMPTY;
  - an input accepted in the flush cycle is discarded;
  - a transfer that coincides with Flush still counts as consumed by the consumer.
- Data registers need not be cleared on Flush. Only the valid bits matter.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system) gives:
  - Out_Valid = 0, Out_Data = 0, Out_SelError = 0, skid cleared, In_Ready = 1.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an input accepted at edge n is visible on Out_Data/Out_Valid after edge n, i.e. one cycle.
- Throughput: one word per cycle while Out_Ready stays high.
- A single stall cycle is absorbed with no bubble at the input.
- In_Ready falls one cycle after the second word is accepted into a stalled buffer. It rises the cycle after the first transfer out of TWO.
- Ordering is strictly FIFO: main always leaves before skid.
- After Flush at edge n: Out_Valid = 0 and In_Ready = 1 from edge n onward.

## Test plan
- Reset and stream:
  - Stimulus: NBits=32, NInputs=4. Drive inputs 0x10,0x11,0x12,0x13. Selector=2, In_Valid=1, Out_Ready=1, 4 cycles, data incrementing by 0x100 each cycle.
  - Required: Out_Data = 0x12, 0x112, 0x212, 0x312 on consecutive cycles, one cycle after each accept; In_Ready held at 1.
- Stall absorption:
  - Stimulus: Out_Ready=0 while 3 words A, B, C are offered back-to-back.
  - Required: A and B accepted; In_Ready=0 when C is offered. Out_Data stays A.
  - Then Out_Ready=1: outputs A, B, C in order, with no loss or duplication.
- Out-of-range selector:
  - Stimulus: NInputs=3, SelBits=2, Selector=3, input 0 = 0xDEAD.
  - Required: Out_Data=0xDEAD with Out_SelError=1. The next word with Selector=1 has Out_SelError=0.
- Flush in TWO state with a simultaneous offer:
  - Stimulus: buffer holds 2 entries; assert Flush while In_Valid=1.
  - Required: next cycle Out_Valid=0 and In_Ready=1; the offered word never appears at the output.
- Asynchronous reset mid-stall:
  - Stimulus: pull reset low between clock edges while in TWO.
  - Required: Out_Valid, Out_Data and Out_SelError go to 0 before the next edge; In_Ready=1.
- Random backpressure:
  - Stimulus: 1000 words, random In_Valid/Out_Ready/Selector, NInputs=5.
  - Required: a scoreboard matches every selected word in order; there is never a transfer while Out_Valid=0.
